// File: rtl/kbd_scan_ctrl.sv
// Keyboard scan-code controller: PS/2 receiver handshake, E0/F0 prefix decode,
// modifier tracking and a FWFT event queue. Define KBD_TYPEMATIC_EN to enqueue repeat makes.
module kbd_scan_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   rx_ready,
    input  logic [7:0]             rx_data,
    input  logic                   rx_overflow,
    output logic                   rx_nextdata_n,
    input  logic                   evt_rd,
    output logic                   evt_valid,
    output logic [11:0]            evt_data,
    output logic                   ctrl_led,
    output logic                   shift_led,
    output logic                   caps_led,
    output logic [$clog2(DEPTH):0] evt_count,
    output logic [7:0]             drop_cnt,
    output logic                   ovf_flag
);

    // state  | meaning
    // S_IDLE | waiting for rx_ready, byte captured on exit
    // S_POP  | captured byte decoded, pop strobe registered low
    // S_WAIT | pop strobe low to receiver, then back to idle
    typedef enum logic [1:0] {S_IDLE, S_POP, S_WAIT} state_t;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
`ifdef KBD_TYPEMATIC_EN
    localparam logic REPEAT_EN = 1'b1;
`else
    localparam logic REPEAT_EN = 1'b0;
`endif

    state_t          state, state_nxt;
    logic            capture;
    logic [7:0]      byte_q, held_code;
    logic            ext_pend, brk_pend;
    logic [11:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;

    logic            decode, is_code, is_ctrl_key, is_shift_key, is_caps_key;
    logic            repeat_make, code_evt, push, pop, full, wr_en;
    logic [11:0]     evt_word;

    always_ff @(posedge clk) begin
        if (clr) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            S_IDLE: if (rx_ready) begin
                state_nxt = S_POP;
                capture   = 1'b1;
            end
            S_POP:   state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        decode       = (state == S_POP);
        is_code      = !(byte_q == 8'hE0 || byte_q == 8'hF0 || byte_q == 8'hFA || byte_q == 8'hAA);
        is_ctrl_key  = (byte_q == 8'h14);
        is_shift_key = (byte_q == 8'h12) || (byte_q == 8'h59);
        is_caps_key  = (byte_q == 8'h58);
        repeat_make  = !brk_pend && (byte_q == held_code);
        code_evt     = decode && is_code;
        push         = code_evt && (!repeat_make || REPEAT_EN);
        // A modifier key's own make/break reports its bit clear (e.g. F0 12 -> 0x812).
        evt_word     = {brk_pend, ext_pend, ctrl_led & ~is_ctrl_key,
                        shift_led & ~is_shift_key, byte_q};
        full         = (evt_count == FULL_CNT);
        pop          = evt_rd && (evt_count != '0);
        wr_en        = push && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            byte_q        <= '0;
            rx_nextdata_n <= 1'b1;
            ext_pend      <= 1'b0;
            brk_pend      <= 1'b0;
            held_code     <= '0;
            ctrl_led      <= 1'b0;
            shift_led     <= 1'b0;
            caps_led      <= 1'b0;
            ovf_flag      <= 1'b0;
            drop_cnt      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            evt_count     <= '0;
        end else begin
            if (capture) byte_q <= rx_data;
            rx_nextdata_n <= (state != S_POP);
            if (rx_overflow) ovf_flag <= 1'b1;

            if (decode && byte_q == 8'hE0) ext_pend <= 1'b1;
            if (decode && byte_q == 8'hF0) brk_pend <= 1'b1;
            if (code_evt) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
                if (!brk_pend) begin
                    if (is_ctrl_key)  ctrl_led  <= 1'b1;
                    if (is_shift_key) shift_led <= 1'b1;
                    if (!repeat_make) begin
                        held_code <= byte_q;
                        if (is_caps_key) caps_led <= ~caps_led;
                    end
                end else begin
                    if (is_ctrl_key)  ctrl_led  <= 1'b0;
                    if (is_shift_key) shift_led <= 1'b0;
                    if (byte_q == held_code) held_code <= '0;
                end
            end

            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
            case ({wr_en, pop})
                2'b10:   evt_count <= evt_count + 1'b1;
                2'b01:   evt_count <= evt_count - 1'b1;
                default: evt_count <= evt_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= evt_word;
    end

    assign evt_valid = (evt_count != '0);
    assign evt_data  = evt_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Self-checking bench for kbd_scan_ctrl: scoreboard of expected events, one task per scenario.
module tb_kbd_scan_ctrl;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_overflow = 1'b0;
    logic        rx_nextdata_n;
    logic        evt_rd = 1'b0;
    logic        evt_valid;
    logic [11:0] evt_data;
    logic        ctrl_led, shift_led, caps_led;
    logic [$clog2(DEPTH):0] evt_count;
    logic [7:0]  drop_cnt;
    logic        ovf_flag;

    int checks = 0;
    int failures = 0;
    int low_cycles = 0;
    logic [11:0] exp_q[$];

    kbd_scan_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .clr(clr), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_overflow(rx_overflow), .rx_nextdata_n(rx_nextdata_n),
        .evt_rd(evt_rd), .evt_valid(evt_valid), .evt_data(evt_data),
        .ctrl_led(ctrl_led), .shift_led(shift_led), .caps_led(caps_led),
        .evt_count(evt_count), .drop_cnt(drop_cnt), .ovf_flag(ovf_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rx_nextdata_n === 1'b0) low_cycles++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Receiver side of one byte; DUT must be idle on entry. Optionally pops the queue
    // on the same edge as the resulting enqueue.
    task automatic send_byte(input logic [7:0] b, input logic rd_on_push);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        if (rd_on_push) begin
            checks++;
            if (evt_valid !== 1'b1 || exp_q.size() == 0 || evt_data !== exp_q[0]) begin
                failures++;
                $display("FAIL rd_on_push_head: got %03h valid=%b expected %03h", evt_data, evt_valid,
                         (exp_q.size() != 0) ? exp_q[0] : 12'h0);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            evt_rd = 1'b1;
        end
        @(negedge clk);
        evt_rd = 1'b0;
        checks++;
        if (rx_nextdata_n !== 1'b0) begin
            failures++;
            $display("FAIL nextdata_low byte %02h: got %b expected 0", b, rx_nextdata_n);
        end
        rx_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_nextdata_n !== 1'b1) begin
            failures++;
            $display("FAIL nextdata_width byte %02h: got %b expected 1", b, rx_nextdata_n);
        end
    endtask

    task automatic drain(input string name);
        while (exp_q.size() > 0) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_data !== exp_q[0]) begin
                failures++;
                $display("FAIL %s evt: got %03h valid=%b expected %03h", name, evt_data, evt_valid, exp_q[0]);
            end
            void'(exp_q.pop_front());
            evt_rd = 1'b1;
            @(negedge clk);
            evt_rd = 1'b0;
        end
        checks++;
        if (evt_valid !== 1'b0 || evt_count !== '0) begin
            failures++;
            $display("FAIL %s empty: got valid=%b count=%0d expected 0/0", name, evt_valid, evt_count);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_nextdata_n !== 1'b1 || evt_valid !== 1'b0 || evt_data !== 12'h000 || evt_count !== '0) begin
            failures++;
            $display("FAIL reset_queue: got nd=%b valid=%b data=%03h count=%0d expected 1/0/000/0",
                     rx_nextdata_n, evt_valid, evt_data, evt_count);
        end
        checks++;
        if ({ctrl_led, shift_led, caps_led} !== 3'b000 || drop_cnt !== 8'd0 || ovf_flag !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: got leds=%b drop=%0d ovf=%b expected 000/0/0",
                     {ctrl_led, shift_led, caps_led}, drop_cnt, ovf_flag);
        end
    endtask

    task automatic test_make_break();
        int base;
        base = low_cycles;
        exp_q.push_back(12'h01C); send_byte(8'h1C, 1'b0);
        checks++;
        if (evt_valid !== 1'b1 || evt_count !== 4'd1) begin
            failures++;
            $display("FAIL make_first_valid: got valid=%b count=%0d expected 1/1", evt_valid, evt_count);
        end
        send_byte(8'hF0, 1'b0);
        exp_q.push_back(12'h81C); send_byte(8'h1C, 1'b0);
        checks++;
        if (low_cycles - base !== 3) begin
            failures++;
            $display("FAIL nextdata_pulses: got %0d low cycles expected 3", low_cycles - base);
        end
        drain("make_break");
        // held_code cleared by the break, so a new make is fresh
        exp_q.push_back(12'h01C); send_byte(8'h1C, 1'b0);
        send_byte(8'hF0, 1'b0);
        exp_q.push_back(12'h81C); send_byte(8'h1C, 1'b0);
        drain("remake");
    endtask

    task automatic test_shift();
        exp_q.push_back(12'h012); send_byte(8'h12, 1'b0);
        checks++;
        if (shift_led !== 1'b1) begin
            failures++; $display("FAIL shift_set: got %b expected 1", shift_led);
        end
        exp_q.push_back(12'h11C); send_byte(8'h1C, 1'b0);
        send_byte(8'hF0, 1'b0);
        exp_q.push_back(12'h91C); send_byte(8'h1C, 1'b0);
        send_byte(8'hF0, 1'b0);
        checks++;
        if (shift_led !== 1'b1) begin
            failures++; $display("FAIL shift_held: got %b expected 1", shift_led);
        end
        exp_q.push_back(12'h812); send_byte(8'h12, 1'b0);
        checks++;
        if (shift_led !== 1'b0) begin
            failures++; $display("FAIL shift_clear: got %b expected 0", shift_led);
        end
        drain("shift");
    endtask

    task automatic test_ctrl();
        send_byte(8'hE0, 1'b0);
        exp_q.push_back(12'h414); send_byte(8'h14, 1'b0);
        checks++;
        if (ctrl_led !== 1'b1) begin
            failures++; $display("FAIL ctrl_set: got %b expected 1", ctrl_led);
        end
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        exp_q.push_back(12'hC14); send_byte(8'h14, 1'b0);
        checks++;
        if (ctrl_led !== 1'b0) begin
            failures++; $display("FAIL ctrl_clear: got %b expected 0", ctrl_led);
        end
        drain("ctrl");
    endtask

    task automatic test_discard();
        send_byte(8'hE0, 1'b0);
        send_byte(8'hFA, 1'b0);
        send_byte(8'hAA, 1'b0);
        exp_q.push_back(12'h41C); send_byte(8'h1C, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'hFA, 1'b0);
        exp_q.push_back(12'h81C); send_byte(8'h1C, 1'b0);
        drain("discard");
    endtask

    task automatic test_caps();
        int exp_cnt;
        exp_q.push_back(12'h058); send_byte(8'h58, 1'b0);
        checks++;
        if (caps_led !== 1'b1) begin
            failures++; $display("FAIL caps_first: got %b expected 1", caps_led);
        end
`ifdef KBD_TYPEMATIC_EN
        exp_q.push_back(12'h058);
        exp_cnt = 4;
`else
        exp_cnt = 3;
`endif
        send_byte(8'h58, 1'b0);
        checks++;
        if (caps_led !== 1'b1) begin
            failures++; $display("FAIL caps_repeat: got %b expected 1", caps_led);
        end
        send_byte(8'hF0, 1'b0);
        exp_q.push_back(12'h858); send_byte(8'h58, 1'b0);
        exp_q.push_back(12'h058); send_byte(8'h58, 1'b0);
        checks++;
        if (caps_led !== 1'b0) begin
            failures++; $display("FAIL caps_toggle: got %b expected 0", caps_led);
        end
        checks++;
        if (evt_count !== exp_cnt[3:0]) begin
            failures++; $display("FAIL caps_count: got %0d expected %0d", evt_count, exp_cnt);
        end
        drain("caps");
        send_byte(8'hF0, 1'b0);
        exp_q.push_back(12'h858); send_byte(8'h58, 1'b0);
        drain("caps_release");
    endtask

    task automatic test_full();
        logic [7:0] codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
        for (int i = 0; i < 9; i++) begin
            if (i < DEPTH) exp_q.push_back({4'h0, codes[i]});
            send_byte(codes[i], 1'b0);
        end
        checks++;
        if (evt_count !== 4'd8 || drop_cnt !== 8'd1) begin
            failures++; $display("FAIL full_drop: got count=%0d drop=%0d expected 8/1", evt_count, drop_cnt);
        end
        exp_q.push_back(12'h04D); send_byte(8'h4D, 1'b1);
        checks++;
        if (evt_count !== 4'd8 || drop_cnt !== 8'd1) begin
            failures++; $display("FAIL full_push_pop: got count=%0d drop=%0d expected 8/1", evt_count, drop_cnt);
        end
        drain("full");
        evt_rd = 1'b1;
        @(negedge clk);
        evt_rd = 1'b0;
        checks++;
        if (evt_count !== '0 || evt_valid !== 1'b0) begin
            failures++; $display("FAIL empty_pop: got count=%0d valid=%b expected 0/0", evt_count, evt_valid);
        end
    endtask

    task automatic test_clr_mid();
        exp_q.push_back(12'h012); send_byte(8'h12, 1'b0);
        exp_q.push_back(12'h12C); send_byte(8'h2C, 1'b0);
        send_byte(8'hF0, 1'b0);
        @(negedge clk); rx_overflow = 1'b1;
        @(negedge clk); rx_overflow = 1'b0;
        @(negedge clk);
        checks++;
        if (ovf_flag !== 1'b1) begin
            failures++; $display("FAIL ovf_sticky: got %b expected 1", ovf_flag);
        end
        rx_data  = 8'h2C;
        rx_ready = 1'b1;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_q.delete();
        checks++;
        if (rx_nextdata_n !== 1'b1 || evt_valid !== 1'b0 || evt_data !== 12'h000 || evt_count !== '0) begin
            failures++;
            $display("FAIL clr_queue: got nd=%b valid=%b data=%03h count=%0d expected 1/0/000/0",
                     rx_nextdata_n, evt_valid, evt_data, evt_count);
        end
        checks++;
        if ({ctrl_led, shift_led, caps_led} !== 3'b000 || drop_cnt !== 8'd0 || ovf_flag !== 1'b0) begin
            failures++;
            $display("FAIL clr_status: got leds=%b drop=%0d ovf=%b expected 000/0/0",
                     {ctrl_led, shift_led, caps_led}, drop_cnt, ovf_flag);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rx_nextdata_n !== 1'b0) begin
            failures++; $display("FAIL clr_repop: got nd=%b expected 0", rx_nextdata_n);
        end
        rx_ready = 1'b0;
        exp_q.push_back(12'h02C);
        @(negedge clk);
        drain("after_clr");
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_shift();
        test_ctrl();
        test_discard();
        test_caps();
        test_full();
        test_clr_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
